// File: rtl/uart_receiver.sv
// uart_receiver: 16x oversampled UART receiver feeding a first-word-fall-through FIFO.
// Default frame is 8N1, LSB first. Define UART_RECEIVER_PARITY_EN to expect an even
// parity bit between the data bits and the stop bit; that build adds parity_error_o.
// Baud select: 00=9600 01=19200 10=57600 11=115200.
`timescale 1ns/1ps
module uart_receiver #(
    parameter int CLOCK_FREQUENCY = 50_000_000,
    parameter int BUFFER_DEPTH    = 16
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       uart_rx_i,
    input  logic [1:0] baudrate_select_i,
    input  logic       data_read_i,
    output logic [7:0] data_o,
    output logic       data_buffer_empty_o,
    output logic       data_buffer_full_o,
    output logic       rx_busy_o,
    output logic       framing_error_o,
    output logic       overrun_o
`ifdef UART_RECEIVER_PARITY_EN
    ,
    output logic       parity_error_o
`endif
);

    localparam int AW = $clog2(BUFFER_DEPTH);
    localparam int PW = AW + 1;

    localparam int DIV_9600_I   = CLOCK_FREQUENCY / (9600 * 16);
    localparam int DIV_19200_I  = CLOCK_FREQUENCY / (19200 * 16);
    localparam int DIV_57600_I  = CLOCK_FREQUENCY / (57600 * 16);
    localparam int DIV_115200_I = CLOCK_FREQUENCY / (115200 * 16);
    localparam int CW           = $clog2(DIV_9600_I + 1);

    localparam logic [CW-1:0] DIV_9600   = CW'(DIV_9600_I);
    localparam logic [CW-1:0] DIV_19200  = CW'(DIV_19200_I);
    localparam logic [CW-1:0] DIV_57600  = CW'(DIV_57600_I);
    localparam logic [CW-1:0] DIV_115200 = CW'(DIV_115200_I);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RECEIVER_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    // Tick-counter reload value (divisor - 1) for a given baud select code.
    function automatic logic [CW-1:0] reload_for(input logic [1:0] sel);
        logic [CW-1:0] div;
        case (sel)
            2'b00:   div = DIV_9600;
            2'b01:   div = DIV_19200;
            2'b10:   div = DIV_57600;
            2'b11:   div = DIV_115200;
            default: div = DIV_115200;
        endcase
        return div - CW'(1'b1);
    endfunction

`ifdef UART_RECEIVER_PARITY_EN
    // Even parity bit: makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    state_t          state_r;
    state_t          state_next_s;
    logic [1:0]      sync_r;
    logic            line_prev_r;
    logic            line_s;
    logic            start_edge_s;
    logic [1:0]      baud_sel_r;
    logic [CW-1:0]   tick_cnt_r;
    logic            tick_s;
    logic [3:0]      os_cnt_r;
    logic [2:0]      bit_cnt_r;
    logic [7:0]      shift_r;
    logic            sample_s;
    logic            shift_en_s;
    logic            push_req_s;
    logic            frame_err_s;
`ifdef UART_RECEIVER_PARITY_EN
    logic            parity_chk_s;
    logic            parity_err_s;
    logic            parity_bad_r;
`endif
    logic [7:0]      mem_r [BUFFER_DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic            empty_s;
    logic            full_s;
    logic            pop_s;
    logic            push_ok_s;
    logic            overrun_s;

    assign line_s       = sync_r[1];
    assign start_edge_s = line_prev_r & ~line_s;
    assign tick_s       = (state_r != ST_IDLE) && (tick_cnt_r == {CW{1'b0}});

    // Bring the asynchronous serial line into the clock domain and keep its previous value for edge detection.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sync_r      <= 2'b11;
            line_prev_r <= 1'b1;
        end else begin
            sync_r      <= {sync_r[0], uart_rx_i};
            line_prev_r <= sync_r[1];
        end
    end

    // Baud tick generator: parked at reload in IDLE, otherwise counts down and reloads after the zero tick.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            tick_cnt_r <= reload_for(2'b00);
            baud_sel_r <= 2'b00;
        end else begin
            if (state_r == ST_IDLE) begin
                tick_cnt_r <= reload_for(baudrate_select_i);
            end else if (tick_cnt_r == {CW{1'b0}}) begin
                tick_cnt_r <= reload_for(baud_sel_r);
            end else begin
                tick_cnt_r <= tick_cnt_r - CW'(1'b1);
            end
            if ((state_r == ST_IDLE) && start_edge_s) begin
                baud_sel_r <= baudrate_select_i;
            end else begin
                baud_sel_r <= baud_sel_r;
            end
        end
    end

    // Sample point: 8th tick in the start bit (mid-bit), every 16th tick afterwards.
    always_comb begin
        sample_s = 1'b0;
        if (!tick_s) begin
            sample_s = 1'b0;
        end else if (state_r == ST_START) begin
            sample_s = (os_cnt_r == 4'd7);
        end else begin
            sample_s = (os_cnt_r == 4'd15);
        end
    end

    // FSM state register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and per-sample control strobes.
    always_comb begin
        state_next_s = state_r;
        shift_en_s   = 1'b0;
        push_req_s   = 1'b0;
        frame_err_s  = 1'b0;
`ifdef UART_RECEIVER_PARITY_EN
        parity_chk_s = 1'b0;
        parity_err_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start_edge_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (sample_s) begin
                    // A start bit that is high again at mid-bit was a glitch.
                    state_next_s = line_s ? ST_IDLE : ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (sample_s) begin
                    shift_en_s = 1'b1;
                    if (bit_cnt_r == 3'd7) begin
`ifdef UART_RECEIVER_PARITY_EN
                        state_next_s = ST_PARITY;
`else
                        state_next_s = ST_STOP;
`endif
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
`ifdef UART_RECEIVER_PARITY_EN
            ST_PARITY: begin
                if (sample_s) begin
                    parity_chk_s = 1'b1;
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (sample_s) begin
                    // Leave mid stop bit so a following start edge is not missed.
                    state_next_s = ST_IDLE;
                    if (!line_s) begin
                        frame_err_s = 1'b1;
`ifdef UART_RECEIVER_PARITY_EN
                    end else if (parity_bad_r) begin
                        parity_err_s = 1'b1;
`endif
                    end else begin
                        push_req_s = 1'b1;
                    end
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Oversample counter, bit counter and data shift register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            os_cnt_r  <= 4'd0;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            if ((state_r == ST_IDLE) || sample_s) begin
                os_cnt_r <= 4'd0;
            end else if (tick_s) begin
                os_cnt_r <= os_cnt_r + 4'd1;
            end else begin
                os_cnt_r <= os_cnt_r;
            end
            if (state_r != ST_DATA) begin
                bit_cnt_r <= 3'd0;
            end else if (shift_en_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
            if (shift_en_s) begin
                shift_r <= {line_s, shift_r[7:1]};
            end else begin
                shift_r <= shift_r;
            end
        end
    end

`ifdef UART_RECEIVER_PARITY_EN
    // Remember a parity mismatch until the stop bit decides the frame's fate.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            parity_bad_r <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            parity_bad_r <= 1'b0;
        end else if (parity_chk_s) begin
            parity_bad_r <= (line_s != even_parity(shift_r));
        end else begin
            parity_bad_r <= parity_bad_r;
        end
    end
`endif

    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_s     = data_read_i && !empty_s;
    assign push_ok_s = push_req_s && (!full_s || pop_s);
    assign overrun_s = push_req_s && !push_ok_s;

    // Receive FIFO storage and pointers; a push into a full FIFO is allowed only alongside a pop.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            for (int i = 0; i < BUFFER_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= shift_r;
                wr_ptr_r                <= wr_ptr_r + PW'(1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    assign data_o              = mem_r[rd_ptr_r[AW-1:0]];
    assign data_buffer_empty_o = empty_s;
    assign data_buffer_full_o  = full_s;

    // Registered status and error pulses.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rx_busy_o       <= 1'b0;
            framing_error_o <= 1'b0;
            overrun_o       <= 1'b0;
`ifdef UART_RECEIVER_PARITY_EN
            parity_error_o  <= 1'b0;
`endif
        end else begin
            rx_busy_o       <= (state_next_s != ST_IDLE);
            framing_error_o <= frame_err_s;
            overrun_o       <= overrun_s;
`ifdef UART_RECEIVER_PARITY_EN
            parity_error_o  <= parity_err_s;
`endif
        end
    end

endmodule
